// File: rtl/cache_pkg.sv
// Shared definitions for the cache line-fill controller: state encoding,
// geometry and address field positions.
package cache_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } fill_state_t;

  localparam int BLOCK_WORDS = 8;
  localparam int NUM_BLOCKS  = 128;
  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 16;

  localparam int TAG_MSB  = 15;
  localparam int TAG_LSB  = 11;
  localparam int IDX_MSB  = 10;
  localparam int IDX_LSB  = 4;
  localparam int WORD_MSB = 3;
  localparam int WORD_LSB = 1;

  localparam int WORD_BITS = WORD_MSB - WORD_LSB + 1;
  localparam int IDX_BITS  = IDX_MSB - IDX_LSB + 1;
  localparam int TAG_BITS  = TAG_MSB - TAG_LSB + 1;
  localparam int BASE_BITS = ADDR_W - IDX_LSB;

  localparam logic [WORD_BITS-1:0] LAST_WORD = 3'd7;

  // Tag array entry: valid bit, two reserved zero bits, then the address tag.
  function automatic logic [7:0] make_tag(input logic [TAG_BITS-1:0] tag);
    return {1'b1, 2'b00, tag};
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Generic N-to-2^N one-hot decoder with an enable; output is all-zero
// when disabled.
module onehot_decoder #(
  parameter int N = 3
) (
  input  logic [N-1:0]      sel,
  input  logic              en,
  output logic [(1<<N)-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache line-fill controller: on a miss, issues eight in-order word reads,
// writes each returned word into the data array, then writes the tag.
//
// state | meaning
// IDLE  | no fill; waiting for miss_detected
// FILL  | issuing word reads (one per cycle), also accepting returned words
// WAIT  | all reads issued; accepting remaining returned words
// DONE  | last word written; one-cycle tag write
module cache_fill_fsm
  import cache_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         miss_detected,
  input  logic [15:0]  miss_address,
  input  logic [15:0]  memory_data,
  input  logic         memory_data_valid,
  output logic         fsm_busy,
  output logic         mem_en,
  output logic [15:0]  memory_address,
  output logic         data_we,
  output logic [7:0]   word_en,
  output logic [15:0]  data_out,
  output logic         tag_we,
  output logic [7:0]   tag_out,
  output logic [127:0] block_en
);

  fill_state_t          state_q, state_d;
  logic [BASE_BITS-1:0] base_q, base_d;
  logic [WORD_BITS-1:0] issue_q, issue_d;
  logic [WORD_BITS-1:0] recv_q, recv_d;

  logic word_dec_en;
  logic block_dec_en;

  // Byte offset bits of the miss address never influence a line fill.
  logic unused_byte_bits;
  assign unused_byte_bits = ^miss_address[WORD_MSB:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      issue_q <= '0;
      recv_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      issue_q <= issue_d;
      recv_q  <= recv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    issue_d = issue_q;
    recv_d  = recv_q;
    case (state_q)
      S_IDLE: begin
        if (miss_detected) begin
          base_d  = miss_address[ADDR_W-1:IDX_LSB];
          issue_d = '0;
          recv_d  = '0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (issue_q != LAST_WORD) issue_d = issue_q + 3'd1;
        else                      state_d = S_WAIT;
        // Last returned word wins over the FILL->WAIT move (zero-latency memory).
        if (memory_data_valid) begin
          if (recv_q != LAST_WORD) recv_d = recv_q + 3'd1;
          else                     state_d = S_DONE;
        end
      end
      S_WAIT: begin
        if (memory_data_valid) begin
          if (recv_q != LAST_WORD) recv_d = recv_q + 3'd1;
          else                     state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes are gated by rst so nothing fires while reset is held.
  always_comb begin
    mem_en       = 1'b0;
    data_we      = 1'b0;
    tag_we       = 1'b0;
    fsm_busy     = 1'b0;
    block_dec_en = 1'b0;
    if (rst) begin
      fsm_busy     = (state_q != S_IDLE) || miss_detected;
      mem_en       = (state_q == S_FILL);
      data_we      = ((state_q == S_FILL) || (state_q == S_WAIT)) && memory_data_valid;
      tag_we       = (state_q == S_DONE);
      block_dec_en = (state_q != S_IDLE);
    end
    word_dec_en    = data_we;
    memory_address = {base_q, issue_q, 1'b0};
    data_out       = memory_data;
    tag_out        = make_tag(base_q[BASE_BITS-1 -: TAG_BITS]);
  end

  onehot_decoder #(.N(WORD_BITS)) u_word_dec (
    .sel    (recv_q),
    .en     (word_dec_en),
    .onehot (word_en)
  );

  onehot_decoder #(.N(IDX_BITS)) u_block_dec (
    .sel    (base_q[IDX_BITS-1:0]),
    .en     (block_dec_en),
    .onehot (block_en)
  );

endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-low reset, sampled on the clk rising edge.
REQ-003 SHALL have port miss_detected, input, 1, cache lookup missed this cycle.
REQ-004 SHALL have port miss_address, input, 16, byte address of the missing access.
REQ-005 SHALL have port memory_data, input, 16, read data returned by main memory.
REQ-006 SHALL have port memory_data_valid, input, 1, memory_data is valid this cycle.
REQ-007 SHALL have port fsm_busy, output, 1, fill in progress; stalls the pipeline.
REQ-008 SHALL have port mem_en, output, 1, memory read request this cycle.
REQ-009 SHALL have port memory_address, output, 16, address of the current memory read request.
REQ-010 SHALL have port data_we, output, 1, write enable to the cache data array.
REQ-011 SHALL have port word_en, output, 8, one-hot word select in the block.
REQ-012 SHALL have port data_out, output, 16, data to the data array; equals memory_data combinationally.
REQ-013 SHALL have port tag_we, output, 1, write enable to the cache tag array.
REQ-014 SHALL have port tag_out, output, 8, tag to be written: {1'b1 valid, 2'b00, addr[15:11]}.
REQ-015 SHALL have port block_en, output, 128, one-hot block select, shared by the data and tag arrays.

Function
REQ-016 Address split SHALL be: addr[15:11] tag, addr[10:4] block index, addr[3:1] word, addr[0] byte.
REQ-017 The state machine SHALL have the states IDLE, FILL, WAIT and DONE.
REQ-018 In IDLE with miss_detected=1, the block SHALL latch miss_address[15:4] and move to FILL; issue_cnt and recv_cnt SHALL be cleared to 0.
REQ-019 fsm_busy SHALL equal (state!=IDLE) | (state==IDLE & miss_detected), combinationally.
REQ-020 In FILL, the block SHALL drive mem_en=1 with memory_address={base,issue_cnt,1'b0} and increment issue_cnt; after issuing word 7 it SHALL move to WAIT.
REQ-021 In WAIT, mem_en SHALL be 0.
REQ-022 In FILL or WAIT with memory_data_valid=1, the block SHALL drive data_we=1 and word_en=onehot(recv_cnt), then increment recv_cnt; otherwise data_we=0 and word_en=0.
REQ-023 A valid word with recv_cnt==7 SHALL move the state to DONE; if this happens while still in FILL, it SHALL take priority.
REQ-024 DONE SHALL last one cycle with tag_we=1, then return to IDLE.
REQ-025 The block SHALL not depend on memory latency; ordering is in-order and each word is written in the cycle its valid arrives.
REQ-026 block_en SHALL be onehot(latched index) in FILL, WAIT and DONE, and all-zero in IDLE.
REQ-027 memory_data_valid in IDLE SHALL be ignored (no writes).
REQ-028 miss_detected while the block is not in IDLE SHALL be ignored.
REQ-029 Counters SHALL be 3-bit and SHALL NOT wrap past 7 within a fill.

Reset
REQ-030 rst=0 SHALL force state=IDLE and clear base, issue_cnt and recv_cnt.
REQ-031 While in reset, mem_en, data_we, tag_we, fsm_busy, word_en and block_en SHALL be 0.
REQ-032 Reset mid-fill SHALL abort the fill with no further writes; the tag is never written, so the block stays invalid.

Structure
REQ-033 Package cache_pkg SHALL hold the state encoding, BLOCK_WORDS=8, NUM_BLOCKS=128 and the address field positions.
REQ-034 Sub-module onehot_decoder (parameterised N-to-2^N) SHALL be used for word_en (3-to-8) and block_en (7-to-128).

Verification
REQ-035 Miss at 0xABCD, memory valid 4 cycles after each request: mem_en cycles 1-8, addresses 0xABC0..0xABCE; data_we cycles 5-12, word_en 0x01..0x80; block_en bit 60; tag_we cycle 13 with tag_out=0x95; IDLE at cycle 14.
REQ-036 Valid gaps (stall 2 cycles after word 3): remains in WAIT, exactly 8 writes in order, then tag_we once.
REQ-037 miss_detected pulsed during a fill: ignored; memory_address sequence is unchanged.
REQ-038 rst=0 after word 4 is written: next cycle IDLE, tag_we never asserted; a new miss at 0x0010 then fills block 1 from word 0.
REQ-039 memory_data_valid=1 in IDLE: data_we=0, block_en=0.
REQ-040 Zero-latency memory (valid in the same cycle as mem_en): the 8th word arrives in FILL; state goes directly to DONE with tag_we at cycle 9.
